phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Control FSM that steps the node processor through the eight algorithm phases, in order:
  - 0 learnCost, 1 amISink, 2 fixSinkList, 3 neighborSinkInOtherCluster
  - 4 findMyBest, 5 betterNeighborsInMyCluster, 6 winnerPolicy, 7 selectMyAction
- Drives the 3-bit select of the downstream 16-bit address multiplexer.
- Drives a one-hot enable to the active phase unit.
- Advances on that unit's done flag and skips phases masked off for the current round.

Parameters:
- TO_W, 16, width of the per-phase watchdog counter.
- TO_LIMIT, 16'd1000, cycles a phase may stay enabled without done before a timeout.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  one-cycle request to begin a round; honoured only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE with no done pulse
- skip_mask  input  8  bit i=1 skips phase i; sampled only on an accepted start
- phase_done  input  8  bit i pulses/holds high when phase unit i finishes
- sel  output  3  phase index to the address mux
- en  output  8  one-hot enable of the active phase; all zero when not running
- busy  output  1  high while a round is in progress
- round_done  output  1  one-cycle pulse when a round completes normally
- timeout_err  output  1  sticky error flag (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sel=0, en=0, busy=0, round_done=0, timeout_err=0.
  - Latched mask and watchdog are cleared.
- States: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge t latches skip_mask into mask_q.
  - first = lowest i with mask_q[i]=0.
  - If first exists: at t+1 state=RUN, sel=first, en=1<<first, busy=1.
  - If mask is all ones: at t+1 state=FIN, en stays 0, busy=1.
- RUN:
  - en[sel] is held high for the whole phase.
  - Only phase_done[sel] is observed; done bits of other phases are ignored.
  - When phase_done[sel]=1 at edge k, find next = lowest i>sel with mask_q[i]=0.
  - If next exists: at k+1 sel=next, en=1<<next, with no idle gap between phases.
  - If none exists: at k+1 state=FIN, en=0, sel holds the last phase index.
- FIN:
  - Lasts one cycle with round_done=1 and busy=1.
  - Next cycle: IDLE, busy=0, round_done=0.
  - Total latency for an all-masked round is start -> round_done at t+2.
- IDLE outputs: sel retains its last value, en=0.
- start while busy: ignored; it does not restart or queue.
- abort=1 in RUN or FIN:
  - Next edge goes to IDLE, en=0, busy=0, no round_done.
  - abort takes priority over phase_done in the same cycle.
  - abort in IDLE is a no-op, even with start=1 in the same cycle; abort wins.
- Asynchronous reset mid-round forces the reset values immediately; the round is lost.
- Phases are never revisited within a round; order is strictly ascending.

Optional Feature:
- Macro: PHASE_TIMEOUT_EN.
- Defined:
  - A TO_W-bit counter clears on every phase entry and increments each RUN cycle while phase_done[sel]=0.
  - When the counter reaches TO_LIMIT, the next edge sets timeout_err=1 (sticky until rst or the next accepted start).
  - The same edge forces IDLE, with en=0, busy=0 and no round_done.
  - phase_done[sel] in the cycle the limit is reached wins; the phase completes normally.
- Not defined: no counter; timeout_err is tied to 0; a phase may remain enabled indefinitely.

Test Plan:
- Full round:
  - Stimulus: skip_mask=8'h00, start at t0, each phase_done[sel] pulsed 3 cycles after its en rises.
  - Required: sel steps 0..7, each en one-hot with no gap, round_done pulses once exactly 1 cycle after phase 7 done, then busy=0.
- Masked round:
  - Stimulus: skip_mask=8'b0111_1100 (sink node).
  - Required: only phases 0, 1, 7 enabled, sel sequence 0->1->7, round_done after phase 7.
- All masked:
  - Stimulus: skip_mask=8'hFF.
  - Required: en stays 0, round_done at t0+2, busy high for exactly 2 cycles.
- Spurious done and start while busy:
  - Stimulus: phase_done[5]=1 while sel=2; also start pulsed mid-round.
  - Required: no advance, round unaffected.
- Abort and reset:
  - Stimulus: abort at sel=4 with phase_done[4]=1 in the same cycle; separately, rst asserted mid-RUN.
  - Required for abort: IDLE, en=0, no round_done.
  - Required for rst: all outputs zero immediately, without waiting for a clock edge.
- Timeout (PHASE_TIMEOUT_EN, TO_LIMIT=10):
  - Stimulus: phase 3 never signals done.
  - Required: timeout_err=1 on the edge after the counter reaches 10, busy=0, en=0.
  - Required: the next start clears timeout_err.

Source files
------------

// File: rtl/phase_sequencer.sv
// Phase sequencer: walks the eight node-processor phases in order, skipping masked ones.
// Optional per-phase watchdog enabled by defining PHASE_TIMEOUT_EN.
module phase_sequencer #(
   parameter int          TO_W     = 16,
   parameter int unsigned TO_LIMIT = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic [7:0] skip_mask,
   input  logic [7:0] phase_done,
   output logic [2:0] sel,
   output logic [7:0] en,
   output logic       busy,
   output logic       round_done,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t     state;
   logic [7:0] mask_q;
   logic [3:0] first_hit;
   logic [3:0] succ_hit;

   if (TO_W < 2 || TO_LIMIT >= (64'd1 << TO_W)) begin : g_bad_cfg
      $error("phase_sequencer: TO_LIMIT does not fit in TO_W bits");
   end

   // {found, index} of the lowest unmasked phase at or above 'from'
   function automatic logic [3:0] next_phase(input logic [7:0] m,
                                             input logic [3:0] from);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (i >= int'(from) && !m[i]) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

   always_comb begin
      first_hit = next_phase(skip_mask, 4'd0);
      succ_hit  = next_phase(mask_q, {1'b0, sel} + 4'd1);
   end

`ifdef PHASE_TIMEOUT_EN
   logic [TO_W-1:0] wd_q;
   logic            terr_q;
   assign timeout_err = terr_q;
`else
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= 3'd0;
         en         <= 8'd0;
         busy       <= 1'b0;
         round_done <= 1'b0;
         mask_q     <= 8'd0;
`ifdef PHASE_TIMEOUT_EN
         wd_q       <= '0;
         terr_q     <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               en         <= 8'd0;
               busy       <= 1'b0;
               round_done <= 1'b0;
               if (start && !abort) begin
                  mask_q <= skip_mask;
                  busy   <= 1'b1;
`ifdef PHASE_TIMEOUT_EN
                  wd_q   <= '0;
                  terr_q <= 1'b0;
`endif
                  if (first_hit[3]) begin
                     state <= RUN;
                     sel   <= first_hit[2:0];
                     en    <= 8'd1 << first_hit[2:0];
                  end else begin
                     state <= FIN;
                  end
               end
            end
            RUN: begin
               if (abort) begin
                  state <= IDLE;
                  en    <= 8'd0;
                  busy  <= 1'b0;
               end else if (phase_done[sel]) begin
`ifdef PHASE_TIMEOUT_EN
                  wd_q <= '0;
`endif
                  if (succ_hit[3]) begin
                     sel <= succ_hit[2:0];
                     en  <= 8'd1 << succ_hit[2:0];
                  end else begin
                     state      <= FIN;
                     en         <= 8'd0;
                     round_done <= 1'b1;
                  end
`ifdef PHASE_TIMEOUT_EN
               end else if (wd_q == TO_W'(TO_LIMIT)) begin
                  state  <= IDLE;
                  en     <= 8'd0;
                  busy   <= 1'b0;
                  terr_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + 1'b1;
`endif
               end
            end
            FIN: begin
               // an all-masked round spends one extra cycle here before the pulse
               if (abort || round_done) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  round_done <= 1'b0;
               end else begin
                  round_done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               en    <= 8'd0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
